// File: rtl/gate_test_sequencer.sv
// gate_test_sequencer: steps a 3-input gate through {a,b,c}=0..7 and checks each output against EXPECT (rev 1.0).
// Optional macro GATE_SEQ_HALT_ON_FAIL_EN: stop at the first mismatching vector instead of running all eight.
`default_nettype none

module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECT        = 8'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       drv_a,
  output logic       drv_b,
  output logic       drv_c,
  output logic [2:0] step,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] obs_vec,
  output logic [7:0] fail_vec
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETTLE = 2'd1;
  localparam logic [1:0] c_SAMPLE = 2'd2;
  localparam logic [1:0] c_DONE   = 2'd3;

  localparam logic [7:0] c_CNT_LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] obs_q, obs_d;
  logic [7:0] fail_q, fail_d;
  logic       w_mismatch;

  assign w_mismatch = (dut_out != EXPECT[step_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      step_q  <= 3'd0;
      cnt_q   <= 8'd0;
      obs_q   <= 8'h00;
      fail_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      obs_q   <= obs_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    obs_d   = obs_q;
    fail_d  = fail_q;
    case (state_q)
      c_IDLE, c_DONE: begin
        if (start) begin
          state_d = c_SETTLE;
          step_d  = 3'd0;
          cnt_d   = 8'd0;
          obs_d   = 8'h00;
          fail_d  = 8'h00;
        end
      end
      c_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == c_CNT_LAST) begin
          state_d = c_SAMPLE;
        end
      end
      c_SAMPLE: begin
        obs_d[step_q]  = dut_out;
        fail_d[step_q] = w_mismatch;
`ifdef GATE_SEQ_HALT_ON_FAIL_EN
        if ((step_q == 3'd7) || w_mismatch) begin
`else
        if (step_q == 3'd7) begin
`endif
          state_d = c_DONE;
        end else begin
          // Step only advances here, so gate inputs stay frozen for the whole settle window
          state_d = c_SETTLE;
          step_d  = step_q + 3'd1;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == c_SETTLE) || (state_q == c_SAMPLE);
    done     = (state_q == c_DONE);
    pass     = (state_q == c_DONE) && (fail_q == 8'h00);
    step     = step_q;
    drv_a    = step_q[2];
    drv_b    = step_q[1];
    drv_c    = step_q[0];
    obs_vec  = obs_q;
    fail_vec = fail_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_gate_test_sequencer.sv
// tb_gate_test_sequencer: table-driven gate models with a scoreboard of expected run results.
`default_nettype none

module tb_gate_test_sequencer;

  localparam int M_NAND = 0;
  localparam int M_ST1  = 1;
  localparam int M_AND  = 2;
  localparam int M_ST0  = 3;
  localparam int M_XOR  = 4;
  localparam int M_OR   = 5;
  localparam int LIMIT  = 300;

  typedef struct {
    int         mode;
    logic [7:0] obs;
    logic [7:0] fail;
    logic       pass;
    logic [2:0] step;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, dut_out, start1;
  logic       drv_a, drv_b, drv_c, busy, done, pass;
  logic [2:0] step;
  logic [7:0] obs_vec, fail_vec;
  logic       dut_out1;
  logic       drv_a1, drv_b1, drv_c1, busy1, done1, pass1;
  logic [2:0] step1;
  logic [7:0] obs_vec1, fail_vec1;

  int   mode;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl [6];
  vec_t sb [$];

  gate_test_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_out(dut_out),
    .drv_a(drv_a), .drv_b(drv_b), .drv_c(drv_c), .step(step),
    .busy(busy), .done(done), .pass(pass),
    .obs_vec(obs_vec), .fail_vec(fail_vec)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dut_out1),
    .drv_a(drv_a1), .drv_b(drv_b1), .drv_c(drv_c1), .step(step1),
    .busy(busy1), .done(done1), .pass(pass1),
    .obs_vec(obs_vec1), .fail_vec(fail_vec1)
  );

  always_comb begin
    dut_out = 1'b0;
    case (mode)
      M_NAND:  dut_out = ~(drv_a & drv_b & drv_c);
      M_ST1:   dut_out = 1'b1;
      M_AND:   dut_out = drv_a & drv_b & drv_c;
      M_ST0:   dut_out = 1'b0;
      M_XOR:   dut_out = drv_a ^ drv_b ^ drv_c;
      M_OR:    dut_out = drv_a | drv_b | drv_c;
      default: dut_out = 1'b0;
    endcase
  end

  assign dut_out1 = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare_result(input string tag, input int lat, input int busy_n);
    vec_t x;
    x = sb.pop_front();
    check({tag, " latency"}, lat, x.lat);
    check({tag, " busy_cycles"}, busy_n, x.lat);
    check({tag, " obs_vec"}, int'(obs_vec), int'(x.obs));
    check({tag, " fail_vec"}, int'(fail_vec), int'(x.fail));
    check({tag, " pass"}, int'(pass), int'(x.pass));
    check({tag, " step"}, int'(step), int'(x.step));
    check({tag, " drv"}, int'({drv_a, drv_b, drv_c}), int'(x.step));
    check({tag, " busy_at_done"}, int'(busy), 0);
  endtask

  // Waits at negedges for done; lat counts edges after the accepting edge.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < LIMIT) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (lat >= LIMIT) check("wait_done timeout", 0, 1);
  endtask

  task automatic run_entry(input vec_t e, input string tag);
    int lat, busy_n;
    mode = e.mode;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, busy_n);
    compare_result(tag, lat, busy_n);
  endtask

  initial begin
    int   lat, busy_n, k;
    vec_t e1;

`ifdef GATE_SEQ_HALT_ON_FAIL_EN
    tbl[0] = '{M_NAND, 8'h7F, 8'h00, 1'b1, 3'd7, 40};
    tbl[1] = '{M_ST1,  8'hFF, 8'h80, 1'b0, 3'd7, 40};
    tbl[2] = '{M_AND,  8'h00, 8'h01, 1'b0, 3'd0, 5};
    tbl[3] = '{M_ST0,  8'h00, 8'h01, 1'b0, 3'd0, 5};
    tbl[4] = '{M_XOR,  8'h00, 8'h01, 1'b0, 3'd0, 5};
    tbl[5] = '{M_OR,   8'h00, 8'h01, 1'b0, 3'd0, 5};
    e1     = '{M_ST0,  8'h00, 8'h01, 1'b0, 3'd0, 2};
`else
    tbl[0] = '{M_NAND, 8'h7F, 8'h00, 1'b1, 3'd7, 40};
    tbl[1] = '{M_ST1,  8'hFF, 8'h80, 1'b0, 3'd7, 40};
    tbl[2] = '{M_AND,  8'h80, 8'hFF, 1'b0, 3'd7, 40};
    tbl[3] = '{M_ST0,  8'h00, 8'h7F, 1'b0, 3'd7, 40};
    tbl[4] = '{M_XOR,  8'h96, 8'hE9, 1'b0, 3'd7, 40};
    tbl[5] = '{M_OR,   8'hFE, 8'h81, 1'b0, 3'd7, 40};
    e1     = '{M_ST0,  8'h00, 8'h7F, 1'b0, 3'd7, 16};
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = M_NAND;
    repeat (2) @(negedge clk);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset pass", int'(pass), 0);
    check("reset step", int'(step), 0);
    check("reset drv", int'({drv_a, drv_b, drv_c}), 0);
    check("reset obs_vec", int'(obs_vec), 0);
    check("reset fail_vec", int'(fail_vec), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle without start", int'(busy), 0);

    for (int i = 0; i < 6; i++) begin
      run_entry(tbl[i], $sformatf("vec%0d", i));
    end

    // Results must hold in DONE while start stays low
    repeat (4) @(negedge clk);
    check("hold done", int'(done), 1);
    check("hold obs_vec", int'(obs_vec), int'(tbl[5].obs));
    check("hold fail_vec", int'(fail_vec), int'(tbl[5].fail));
    check("hold step", int'(step), int'(tbl[5].step));

    // start held high: no restart while busy, restart on the edge after done
    mode = M_NAND;
    sb.push_back(tbl[0]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done(lat, busy_n);
    compare_result("held_start", lat, busy_n);
    @(negedge clk);
    check("restart done", int'(done), 0);
    check("restart busy", int'(busy), 1);
    check("restart step", int'(step), 0);
    check("restart obs_vec", int'(obs_vec), 0);
    check("restart fail_vec", int'(fail_vec), 0);
    start = 1'b0;
    @(negedge clk);
    sb.push_back(tbl[0]);
    wait_done(lat, busy_n);
    // Already one edge into this run when the wait began
    compare_result("held_start_2", lat + 1, busy_n + 1);

    // Asynchronous reset while step=3 is settling
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (step != 3'd3 && k < LIMIT) begin
      @(negedge clk);
      k++;
    end
    check("reach step3", int'(step), 3);
    check("pre_reset obs_vec", int'(obs_vec), 8'h07);
    check("pre_reset busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", int'(busy), 0);
    check("async rst done", int'(done), 0);
    check("async rst step", int'(step), 0);
    check("async rst drv", int'({drv_a, drv_b, drv_c}), 0);
    check("async rst obs_vec", int'(obs_vec), 0);
    check("async rst fail_vec", int'(fail_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst idle", int'(busy), 0);

    // Stuck-at-0 gate with SETTLE_CYCLES=1
    sb.push_back(e1);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    e1 = sb.pop_front();
    check("s1 latency", lat, e1.lat);
    check("s1 obs_vec", int'(obs_vec1), int'(e1.obs));
    check("s1 fail_vec", int'(fail_vec1), int'(e1.fail));
    check("s1 step", int'(step1), int'(e1.step));
    check("s1 pass", int'(pass1), int'(e1.pass));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Self-test controller for the 3-input logic gate datapath: switch inputs a/b/c, one LED output.
- Drives the gate inputs through all 8 combinations {a,b,c} = 0..7 in order and waits a settle time after each.
- Samples the gate output and compares it against a parameterised expected truth table.
- Reports per-combination observed values, mismatches and an overall pass/fail result on board LEDs.

Parameters:
- SETTLE_CYCLES, 4, clock cycles each vector is held before sampling; legal values are 1 to 255.
- EXPECT, 8'h7F, expected truth table; bit i is the expected output for vector i = {a,b,c}. The default is the NAND3 truth table.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  run request; level-sampled each clock, no pulse shaping required.
- dut_out  in  1  gate output (the LED signal).
- drv_a  out  1  gate input a; equals step[2].
- drv_b  out  1  gate input b; equals step[1].
- drv_c  out  1  gate input c; equals step[0].
- step  out  3  current vector index.
- busy  out  1  high while in SETTLE or SAMPLE.
- done  out  1  high in the DONE state.
- pass  out  1  done && (fail_vec == 0).
- obs_vec  out  8  captured gate output per vector index.
- fail_vec  out  8  mismatch flag per vector index.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state = IDLE.
  - step = 0, so drv_a/b/c = 0.
  - busy, done and pass = 0.
  - obs_vec and fail_vec = 8'h00.
  - Settle counter = 0.
- All outputs are registered or decoded from registers only. There is no combinational path from dut_out or start to any output.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start = 1 → SETTLE.
  - On that same edge: step = 0, cnt = 0, obs_vec and fail_vec cleared.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1 → SAMPLE.
  - Each vector is held in SETTLE for exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - obs_vec[step] <= dut_out.
  - fail_vec[step] <= (dut_out != EXPECT[step]).
  - If step == 7 → DONE.
  - Otherwise step <= step+1, cnt <= 0 → SETTLE.
- DONE:
  - Results and step (= 7) hold.
  - start = 1 → restart exactly as from IDLE; results are cleared on the same edge.
- Inputs a/b/c change only on edges leaving SAMPLE or leaving IDLE/DONE. They are never changed mid-settle.
- start is ignored while busy.
- Latency: done rises 8*(SETTLE_CYCLES+1) edges after the edge that accepted start. This is 40 edges for the default.
- step never wraps. 7 is terminal; the next vector is 0 only via restart.

Optional Feature:
- Macro: GATE_SEQ_HALT_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE sends the block to DONE on the next edge.
  - step holds the failing index.
  - obs_vec and fail_vec bits above that index stay 0.
- Undefined: all 8 vectors always run. Mismatches are only recorded.

Test Plan:
- Ideal NAND3 model, default parameters, start pulsed for 1 cycle → busy for 40 cycles, then done=1, obs_vec=8'h7F, fail_vec=8'h00, pass=1, drv_a/b/c = 1/1/1.
- Stuck-at-1 gate → obs_vec=8'hFF, fail_vec=8'h80, pass=0.
- AND3 model instead of NAND3 → obs_vec=8'h80, fail_vec=8'hFF, pass=0.
- start held high through a full run → no restart while busy. After done, the next sampled start clears the results and step=0 on the same edge.
- Reset asserted while step=3 in SETTLE → state IDLE, drv=000, busy=0 and obs_vec/fail_vec = 0 before the next clock edge.
- Stuck-at-0 gate with SETTLE_CYCLES=1:
  - GATE_SEQ_HALT_ON_FAIL_EN defined → done after 2 edges, step=0, fail_vec=8'h01.
  - Macro undefined → done after 16 edges, fail_vec=8'h7F.
